// File: rtl/sdc_user_resp_if.sv
// User request port of the SDRAM controller: initiator drives requests, responder acks and paces beats.
// The master modport is the initiator side; the slave modport is the responder side.
interface sdc_user_resp_if #(
    parameter int U_ADDR_W = 23,
    parameter int U_DATA_W = 32
);
    logic                  sdc_en;
    logic                  sdc_req;
    logic [U_ADDR_W-1:0]   sdc_req_adr;
    logic [1:0]            sdc_req_len;
    logic                  sdc_req_wr_n;
    logic [U_DATA_W-1:0]   sdc_wr_data;
    logic [U_DATA_W/8-1:0] sdc_wr_en_n;
    logic [2:0]            sdc_cas;
    logic [11:0]           sdc_rfrsh;
    logic                  sdc_init_done;
    logic                  sdc_req_ack;
    logic                  sdc_wr_next;
    logic                  sdc_rd_valid;
    logic [U_DATA_W-1:0]   sdc_rd_data;

    modport master (
        output sdc_en, sdc_req, sdc_req_adr, sdc_req_len, sdc_req_wr_n,
               sdc_wr_data, sdc_wr_en_n, sdc_cas, sdc_rfrsh,
        input  sdc_init_done, sdc_req_ack, sdc_wr_next, sdc_rd_valid, sdc_rd_data
    );

    modport slave (
        input  sdc_en, sdc_req, sdc_req_adr, sdc_req_len, sdc_req_wr_n,
               sdc_wr_data, sdc_wr_en_n, sdc_cas, sdc_rfrsh,
        output sdc_init_done, sdc_req_ack, sdc_wr_next, sdc_rd_valid, sdc_rd_data
    );
endinterface

// File: rtl/sdc_user_resp.sv
// SDRAM-controller stand-in: ack 1 cycle after request, write beats paced by sdc_wr_next, reads at CAS 2/3.
// No backpressure from the initiator; `define REFRESH_STALL_EN adds idle-time refresh stalls.
module sdc_user_resp #(
    parameter int U_ADDR_W = 23,
    parameter int U_DATA_W = 32,
    parameter int MEM_AW   = 9,
    parameter int INIT_CYC = 16
) (
    input  logic           sdc_clk,
    input  logic           s_reset,
    sdc_user_resp_if.slave bus
);
    localparam int BYTES  = U_DATA_W / 8;
    localparam int INIT_W = $clog2(INIT_CYC + 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACK,
        ST_WRITE,
        ST_RLAT,
        ST_READ
`ifdef REFRESH_STALL_EN
        , ST_RFSH
`endif
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [INIT_W-1:0]   r_init_cnt;
    logic                r_init_done;
    logic                r_armed;
    logic [MEM_AW-1:0]   r_base;
    logic [5:0]          r_n;
    logic [5:0]          r_beat;
    logic                r_wr_n;
    logic [1:0]          r_lat;
    logic [1:0]          r_lat_cnt;
    logic                r_rd_valid;
    logic [U_DATA_W-1:0] r_rd_data;
    logic [U_DATA_W-1:0] r_mem [0:(1<<MEM_AW)-1];

    logic                w_accept;
    logic                w_take;
    logic                w_init_end;
    logic                w_lat_end;
    logic                w_rd_fire;
    logic                w_wr_beat;
    logic                w_ack;
    logic                w_wr_next;
    logic [1:0]          w_cas_lat;
    logic [MEM_AW-1:0]   w_addr;
    logic                w_unused_bits;

    assign w_accept   = bus.sdc_req && r_armed && bus.sdc_en;
    assign w_take     = (w_next == ST_ACK) && (r_state != ST_ACK);
    assign w_init_end = (r_init_cnt == INIT_W'(INIT_CYC - 1));
    assign w_lat_end  = (r_lat_cnt == r_lat - 2'd2);
    assign w_cas_lat  = (bus.sdc_cas == 3'd2) ? 2'd2 : 2'd3;
    assign w_addr     = r_base + MEM_AW'(r_beat);
    assign w_wr_beat  = (r_state == ST_WRITE) && !s_reset;
    // rd_valid is registered, so the first beat is launched on the last RLAT cycle
    assign w_rd_fire  = ((r_state == ST_RLAT) && w_lat_end) ||
                        ((r_state == ST_READ) && (r_beat != r_n));

`ifdef REFRESH_STALL_EN
    logic [11:0] r_rf_cnt;
    logic        r_rf_due;

    always_ff @(posedge sdc_clk) begin
        if (s_reset) begin
            r_rf_cnt <= '0;
            r_rf_due <= 1'b0;
        end else if ((r_state == ST_INIT) || ((r_state == ST_RFSH) && (r_beat == 6'd7))) begin
            r_rf_cnt <= bus.sdc_rfrsh;
            r_rf_due <= 1'b0;
        end else if (bus.sdc_rfrsh == 12'd0) begin
            r_rf_due <= 1'b0;
        end else if (r_rf_cnt == 12'd0) begin
            r_rf_due <= 1'b1;
        end else begin
            r_rf_cnt <= r_rf_cnt - 12'd1;
        end
    end

    assign w_unused_bits = ^bus.sdc_req_adr[U_ADDR_W-1:MEM_AW];
`else
    assign w_unused_bits = ^{bus.sdc_req_adr[U_ADDR_W-1:MEM_AW], bus.sdc_rfrsh};
`endif

    always_ff @(posedge sdc_clk) begin
        if (s_reset) r_state <= ST_INIT;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:  if (w_init_end) w_next = ST_IDLE;
`ifdef REFRESH_STALL_EN
            ST_IDLE:  if (r_rf_due) w_next = ST_RFSH;
                      else if (w_accept) w_next = ST_ACK;
            ST_RFSH:  if (r_beat == 6'd7) w_next = w_accept ? ST_ACK : ST_IDLE;
`else
            ST_IDLE:  if (w_accept) w_next = ST_ACK;
`endif
            ST_ACK:   w_next = r_wr_n ? ST_RLAT : ST_WRITE;
            ST_WRITE: if (r_beat == r_n - 6'd1) w_next = ST_IDLE;
            ST_RLAT:  if (w_lat_end) w_next = ST_READ;
            ST_READ:  if (r_beat == r_n) w_next = ST_IDLE;
            default:  w_next = ST_INIT;
        endcase
    end

    always_comb begin
        w_ack     = 1'b0;
        w_wr_next = 1'b0;
        case (r_state)
            ST_ACK:   w_ack     = 1'b1;
            ST_WRITE: w_wr_next = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge sdc_clk) begin
        if (s_reset) begin
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_armed     <= 1'b0;
            r_base      <= '0;
            r_n         <= '0;
            r_beat      <= '0;
            r_wr_n      <= 1'b0;
            r_lat       <= '0;
            r_lat_cnt   <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                if (w_init_end) r_init_done <= 1'b1;
                else            r_init_cnt  <= r_init_cnt + INIT_W'(1);
            end

            // A dropped request re-arms even in the ack cycle itself
            if (!bus.sdc_req)  r_armed <= 1'b1;
            else if (w_ack)    r_armed <= 1'b0;

            if (w_take) begin
                r_base <= bus.sdc_req_adr[MEM_AW-1:0];
                r_n    <= 6'd4 << bus.sdc_req_len;
                r_wr_n <= bus.sdc_req_wr_n;
                r_lat  <= w_cas_lat;
                r_beat <= '0;
            end else if ((r_state == ST_WRITE) || w_rd_fire) begin
                r_beat <= r_beat + 6'd1;
`ifdef REFRESH_STALL_EN
            end else if ((r_state == ST_IDLE) && (w_next == ST_RFSH)) begin
                r_beat <= '0;
            end else if (r_state == ST_RFSH) begin
                r_beat <= r_beat + 6'd1;
`endif
            end

            if (r_state == ST_ACK)       r_lat_cnt <= '0;
            else if (r_state == ST_RLAT) r_lat_cnt <= r_lat_cnt + 2'd1;

            r_rd_valid <= w_rd_fire;
            if (w_rd_fire) r_rd_data <= r_mem[w_addr];
        end
    end

    // Memory keeps its contents across reset
    always_ff @(posedge sdc_clk) begin
        if (w_wr_beat) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!bus.sdc_wr_en_n[b]) r_mem[w_addr][b*8 +: 8] <= bus.sdc_wr_data[b*8 +: 8];
            end
        end
    end

    assign bus.sdc_init_done = r_init_done;
    assign bus.sdc_req_ack   = w_ack;
    assign bus.sdc_wr_next   = w_wr_next;
    assign bus.sdc_rd_valid  = r_rd_valid;
    assign bus.sdc_rd_data   = r_rd_data;
endmodule

// File: tb/tb_sdc_user_resp.sv
// Directed bench for sdc_user_resp: transaction table with a reference word memory, plus hand sequences
// for init timing, held-request re-arming, sdc_en gating and reset in mid-burst.
module tb_sdc_user_resp;
    logic sdc_clk;
    logic s_reset;
    int   errs;
    int   checks;

    logic [31:0] m_mem [0:511];

    typedef struct {
        logic        wr_n;
        logic [22:0] adr;
        logic [1:0]  len;
        logic [2:0]  cas;
        logic [31:0] d0;
        logic [31:0] dstep;
        logic [3:0]  mask;
        int          exp_lat;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    vec_t tbl [12];

    sdc_user_resp_if #(.U_ADDR_W(23), .U_DATA_W(32)) u_if ();

    sdc_user_resp #(.U_ADDR_W(23), .U_DATA_W(32), .MEM_AW(9), .INIT_CYC(16)) u_dut (
        .sdc_clk (sdc_clk),
        .s_reset (s_reset),
        .bus     (u_if.slave)
    );

    initial begin
        sdc_clk = 1'b0;
        forever #5 sdc_clk = ~sdc_clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] mask);
        for (int b = 0; b < 4; b++)
            if (!mask[b]) m_mem[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic do_txn(input vec_t v, input string nm);
        int n, first, lastk, cnt, excl, xack;
        logic [8:0]  a;
        logic [31:0] wdat;
        logic [31:0] last_rd;
        n = 4 << v.len;
        first = -1; lastk = -1; cnt = 0; excl = 0; xack = 0; last_rd = '0;
        @(negedge sdc_clk);
        u_if.sdc_req      = 1'b1;
        u_if.sdc_req_adr  = v.adr;
        u_if.sdc_req_len  = v.len;
        u_if.sdc_req_wr_n = v.wr_n;
        u_if.sdc_cas      = v.cas;
        @(negedge sdc_clk);
        chk({nm, ".ack"}, 32'(u_if.sdc_req_ack), 32'd1);
        // Disturb the request fields to show they were latched at acceptance
        u_if.sdc_req      = 1'b0;
        u_if.sdc_req_adr  = v.adr ^ 23'h0000AA;
        u_if.sdc_req_len  = ~v.len;
        u_if.sdc_req_wr_n = ~v.wr_n;
        u_if.sdc_cas      = (v.cas == 3'd2) ? 3'd3 : 3'd2;
        for (int k = 1; k <= n + v.exp_lat + 4; k++) begin
            @(negedge sdc_clk);
            if (u_if.sdc_req_ack) xack++;
            if (u_if.sdc_wr_next && u_if.sdc_rd_valid) excl++;
            a = v.adr[8:0] + 9'(cnt);
            if (!v.wr_n && u_if.sdc_wr_next) begin
                if (first < 0) first = k;
                lastk = k;
                wdat = v.d0 + v.dstep * 32'(cnt);
                u_if.sdc_wr_data = wdat;
                u_if.sdc_wr_en_n = v.mask;
                model_write(a, wdat, v.mask);
                cnt++;
            end else if (v.wr_n && u_if.sdc_rd_valid) begin
                if (first < 0) first = k;
                lastk = k;
                chk({nm, ".data"}, u_if.sdc_rd_data, m_mem[a]);
                if (cnt == 0)     chk({nm, ".first_word"}, u_if.sdc_rd_data, v.exp_first);
                if (cnt == n - 1) chk({nm, ".last_word"}, u_if.sdc_rd_data, v.exp_last);
                last_rd = u_if.sdc_rd_data;
                cnt++;
            end
        end
        chk({nm, ".latency"}, 32'(first), 32'(v.exp_lat));
        chk({nm, ".beats"}, 32'(cnt), 32'(n));
        chk({nm, ".contiguous"}, 32'(lastk - first + 1), 32'(n));
        chk({nm, ".extra_ack"}, 32'(xack), 32'd0);
        chk({nm, ".exclusive"}, 32'(excl), 32'd0);
        if (v.wr_n) chk({nm, ".rd_hold"}, u_if.sdc_rd_data, last_rd);
    endtask

    task automatic check_init(input string nm);
        for (int i = 1; i <= 16; i++) begin
            @(negedge sdc_clk);
            chk($sformatf("%s.init_done_c%0d", nm, i), 32'(u_if.sdc_init_done), (i == 16) ? 32'd1 : 32'd0);
            chk($sformatf("%s.quiet_c%0d", nm, i),
                {29'd0, u_if.sdc_req_ack, u_if.sdc_wr_next, u_if.sdc_rd_valid}, 32'd0);
        end
    endtask

    initial begin
        int acks, cnt;
        vec_t rv;
        errs = 0;
        checks = 0;

        //         wr_n  adr           len   cas   d0            dstep  mask     lat first         last
        tbl[0]  = '{1'b0, 23'h000200, 2'd0, 3'd3, 32'h00000000, 32'd1, 4'b0000, 1, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, 23'h000200, 2'd0, 3'd3, 32'h0,        32'd0, 4'b0000, 3, 32'h00000000, 32'h00000003};
        tbl[2]  = '{1'b0, 23'h0001F8, 2'd1, 3'd3, 32'h11111111, 32'd0, 4'b0000, 1, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 23'h0001F8, 2'd1, 3'd3, 32'hAAAAAAAA, 32'd0, 4'b0101, 1, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 23'h0001F8, 2'd1, 3'd2, 32'h0,        32'd0, 4'b0000, 2, 32'hAA11AA11, 32'hAA11AA11};
        tbl[5]  = '{1'b0, 23'h7FFFFE, 2'd0, 3'd3, 32'h00000100, 32'd1, 4'b0000, 1, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 23'h0001FE, 2'd0, 3'd6, 32'h0,        32'd0, 4'b0000, 3, 32'h00000100, 32'h00000103};
        tbl[7]  = '{1'b1, 23'h000000, 2'd0, 3'd7, 32'h0,        32'd0, 4'b0000, 3, 32'h00000102, 32'h00000003};
        tbl[8]  = '{1'b0, 23'h000040, 2'd3, 3'd3, 32'hC0DE0000, 32'd1, 4'b0000, 1, 32'h0,        32'h0};
        tbl[9]  = '{1'b1, 23'h000040, 2'd3, 3'd2, 32'h0,        32'd0, 4'b0000, 2, 32'hC0DE0000, 32'hC0DE001F};
        tbl[10] = '{1'b0, 23'h000040, 2'd0, 3'd3, 32'hFFFFFFFF, 32'd0, 4'b1110, 1, 32'h0,        32'h0};
        tbl[11] = '{1'b1, 23'h000040, 2'd0, 3'd3, 32'h0,        32'd0, 4'b0000, 3, 32'hC0DE00FF, 32'hC0DE00FF};

        s_reset           = 1'b1;
        u_if.sdc_en       = 1'b1;
        u_if.sdc_req      = 1'b0;
        u_if.sdc_req_adr  = '0;
        u_if.sdc_req_len  = '0;
        u_if.sdc_req_wr_n = 1'b1;
        u_if.sdc_wr_data  = '0;
        u_if.sdc_wr_en_n  = '0;
        u_if.sdc_cas      = 3'd3;
        u_if.sdc_rfrsh    = 12'd0;

        repeat (3) @(negedge sdc_clk);
        chk("reset.outputs",
            {27'd0, u_if.sdc_init_done, u_if.sdc_req_ack, u_if.sdc_wr_next, u_if.sdc_rd_valid, 1'b0}, 32'd0);
        chk("reset.rd_data", u_if.sdc_rd_data, 32'd0);
        s_reset = 1'b0;
        check_init("init");

        for (int i = 0; i < 12; i++) do_txn(tbl[i], $sformatf("v%0d", i));

        // A level held high is accepted once; a one-cycle drop re-arms it
        @(negedge sdc_clk);
        u_if.sdc_req = 1'b1; u_if.sdc_req_wr_n = 1'b1; u_if.sdc_req_adr = 23'h000200;
        u_if.sdc_req_len = 2'd0; u_if.sdc_cas = 3'd2;
        acks = 0;
        repeat (30) begin @(negedge sdc_clk); if (u_if.sdc_req_ack) acks++; end
        chk("held.first_window", 32'(acks), 32'd1);
        u_if.sdc_req = 1'b0;
        @(negedge sdc_clk);
        if (u_if.sdc_req_ack) acks++;
        u_if.sdc_req = 1'b1;
        repeat (30) begin @(negedge sdc_clk); if (u_if.sdc_req_ack) acks++; end
        chk("held.second_window", 32'(acks), 32'd2);
        u_if.sdc_req = 1'b0; u_if.sdc_en = 1'b0;
        @(negedge sdc_clk);
        u_if.sdc_req = 1'b1;
        repeat (20) begin @(negedge sdc_clk); if (u_if.sdc_req_ack) acks++; end
        chk("en_low.no_ack", 32'(acks), 32'd2);
        u_if.sdc_en = 1'b1;
        repeat (5) begin @(negedge sdc_clk); if (u_if.sdc_req_ack) acks++; end
        chk("en_high.ack", 32'(acks), 32'd3);
        u_if.sdc_req = 1'b0;
        repeat (12) @(negedge sdc_clk);

        // Reset lands in front of beat 5 of a 16-beat write
        u_if.sdc_req = 1'b1; u_if.sdc_req_wr_n = 1'b0; u_if.sdc_req_adr = 23'h000100; u_if.sdc_req_len = 2'd2;
        @(negedge sdc_clk);
        chk("rst_burst.ack", 32'(u_if.sdc_req_ack), 32'd1);
        u_if.sdc_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20 && !s_reset; k++) begin
            @(negedge sdc_clk);
            if (u_if.sdc_wr_next) begin
                if (cnt == 5) begin
                    s_reset = 1'b1;
                end else begin
                    u_if.sdc_wr_data = 32'h50000000 + 32'(cnt);
                    u_if.sdc_wr_en_n = 4'b0000;
                    model_write(9'h100 + 9'(cnt), 32'h50000000 + 32'(cnt), 4'b0000);
                    cnt++;
                end
            end
        end
        chk("rst_burst.reached_beat5", 32'(s_reset), 32'd1);
        @(negedge sdc_clk);
        chk("rst_burst.outputs",
            {27'd0, u_if.sdc_init_done, u_if.sdc_req_ack, u_if.sdc_wr_next, u_if.sdc_rd_valid, 1'b0}, 32'd0);
        chk("rst_burst.rd_data", u_if.sdc_rd_data, 32'd0);
        s_reset = 1'b0;
        check_init("reinit");

        rv = '{1'b1, 23'h000100, 2'd0, 3'd2, 32'h0, 32'd0, 4'b0000, 2, 32'h50000000, 32'h50000003};
        do_txn(rv, "rst_rd0");
        rv = '{1'b1, 23'h000101, 2'd0, 3'd3, 32'h0, 32'd0, 4'b0000, 3, 32'h50000001, 32'h50000004};
        do_txn(rv, "rst_rd1");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1);
    end
endmodule
